// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit ADD/SUB/ADC/SBC with NZCV flags; ADDSUB_SAT_EN adds a per-bundle signed-saturate port.
// Latency: STAGES cycles from accept edge to out_valid, one bundle per cycle.
// Backpressure: whole pipe freezes (bubbles included) while out_valid=1 and out_ready=0.
module addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int L     = STAGES - 1;

  logic             adv;
  logic [WIDTH-1:0] bop;
  logic             c0;
  logic             sat_in;

  // Stage k holds the bundle whose chunk k is added on the way to stage k+1
  logic [STAGES-1:0] st_v;
  logic [WIDTH-1:0]  st_a [STAGES];
  logic [WIDTH-1:0]  st_b [STAGES];
  logic [WIDTH-1:0]  st_r [STAGES];
  logic              st_c [STAGES];
  logic              st_s [STAGES];

  logic [CHUNK:0]    sum  [STAGES];
  logic [WIDTH-1:0]  nx_r [STAGES];

  logic [WIDTH-1:0]  raw;
  logic [WIDTH-1:0]  fin;
  logic              ovf;
  logic [3:0]        flags_nx;

`ifdef ADDSUB_SAT_EN
  assign sat_in = sat;
`else
  assign sat_in = 1'b0;
`endif

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // op[0] selects subtract-style inversion, op[1] selects the external carry
  always_comb begin
    bop = op[0] ? ~b : b;
    c0  = op[1] ? cin : op[0];
  end

  // Carry look-ahead over 4-bit P/G groups; a short tail group ripples
  function automatic logic [CHUNK:0] cla_add(input logic [CHUNK-1:0] x,
                                             input logic [CHUNK-1:0] y,
                                             input logic             ci);
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;
    int               base;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    base = 0;
    for (int grp = 0; grp < CHUNK / 4; grp++) begin
      base       = grp * 4;
      c[base+1]  = g[base]   | (p[base]   & c[base]);
      c[base+2]  = g[base+1] | (p[base+1] & c[base+1]);
      c[base+3]  = g[base+2] | (p[base+2] & c[base+2]);
      c[base+4]  = g[base+3]
                 | (p[base+3] & g[base+2])
                 | (p[base+3] & p[base+2] & g[base+1])
                 | (p[base+3] & p[base+2] & p[base+1] & g[base])
                 | ((&p[base +: 4]) & c[base]);
    end
    for (int i = (CHUNK / 4) * 4; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[CHUNK], p ^ c[CHUNK-1:0]};
  endfunction

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum[k]  = cla_add(st_a[k][k*CHUNK +: CHUNK], st_b[k][k*CHUNK +: CHUNK], st_c[k]);
      nx_r[k] = st_r[k];
      nx_r[k][k*CHUNK +: CHUNK] = sum[k][CHUNK-1:0];
    end
  end

  always_comb begin
    raw = nx_r[L];
    ovf = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1]) & (raw[WIDTH-1] != st_a[L][WIDTH-1]);
    fin = raw;
    if (st_s[L] && ovf) begin
      fin = st_a[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    flags_nx = {fin[WIDTH-1], (fin == '0), sum[L][CHUNK], ovf};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_v      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      st_v[0] <= in_valid;
      st_a[0] <= a;
      st_b[0] <= bop;
      st_c[0] <= c0;
      st_r[0] <= '0;
      st_s[0] <= sat_in;
      for (int k = 1; k < STAGES; k++) begin
        st_v[k] <= st_v[k-1];
        st_a[k] <= st_a[k-1];
        st_b[k] <= st_b[k-1];
        st_c[k] <= sum[k-1][CHUNK];
        st_r[k] <= nx_r[k-1];
        st_s[k] <= st_s[k-1];
      end
      out_valid <= st_v[L];
      // Bubbles leave the last result on the outputs
      if (st_v[L]) begin
        result <= fin;
        flags  <= flags_nx;
      end
    end
  end

endmodule
